// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//
// Synchronous circular-buffer FIFO with configurable width and depth. It sits
// between the MMIO write decode (producer) and the consuming logic (consumer)
// in a single clock domain.
//
// Handshake semantics (both sides):
//   - A push is accepted when wr_en is high and the FIFO is not full, or when
//     it is full but a pop is accepted in the same cycle. Rejected push data is
//     discarded and sets the sticky overflow flag.
//   - A pop is accepted when rd_en is high and the FIFO is not empty. There is
//     no empty bypass: a push and pop on an empty FIFO accepts only the push
//     and sets the sticky underflow flag.
//   - Popped data appears on q after the accepting edge, with a one-cycle
//     q_valid pulse. Without an accepted pop q holds its value.
//   - full/empty/almost_full/count reflect state after the most recent edge so
//     the producer/consumer can gate requests in the same cycle.
//
// Parameters:
//   WIDTH      data word width (>= 1)
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full asserts when count >= AF_THRESH (1..DEPTH)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset (overrides push/pop)
//   wr_en, d     push request and data
//   rd_en        pop request
//   clr_err      clears overflow/underflow (a same-cycle error event wins)
//   q, q_valid   registered pop data and one-cycle valid pulse
//   full, empty, almost_full, count   occupancy status
//   overflow, underflow               sticky error flags
// -----------------------------------------------------------------------------
module fifo_sync_param #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         d,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_w, empty_w;
    logic             wr_ok, rd_ok;

    // Status decoded straight from the occupancy register.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        rd_ok = rd_en && !empty_w;
        // A full FIFO can still take a push when a pop frees a slot this cycle.
        wr_ok = wr_en && (!full_w || rd_ok);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        q_d         = q_q;
        q_valid_d   = 1'b0;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            q_d       = mem_q[rd_ptr_q];
            q_valid_d = 1'b1;
        end

        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);

        // Set has priority over clear so no error event is ever lost.
        overflow_d  = (overflow_q  && !clr_err) || (wr_en && !wr_ok);
        underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_ok);
    end

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign q           = q_q;
    assign q_valid     = q_valid_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Bench for fifo_sync_param at its default parameters (WIDTH=64, DEPTH=8,
// AF_THRESH=6). Directed vectors with hand-written expectations, hand-written
// multi-cycle sequences, and randomized traffic compared against a queue-based
// reference model that tracks every cycle.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [WIDTH-1:0] d;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [3:0]       count;
  logic             overflow;
  logic             underflow;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fifo_sync_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_THRESH(AF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .d          (d),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .q          (q),
    .q_valid    (q_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_q;
  logic             m_qv;
  logic             m_ovf;
  logic             m_unf;

  task automatic model_step(input logic r, input logic wr, input logic rd,
                            input logic clr, input logic [WIDTH-1:0] din);
    logic rd_ok, wr_ok;
    if (r) begin
      exp_q.delete();
      m_q   = '0;
      m_qv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    rd_ok = rd && (exp_q.size() != 0);
    wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok);
    if (rd_ok) m_q = exp_q.pop_front();
    m_qv = rd_ok;
    if (wr_ok) exp_q.push_back(din);
    m_ovf = (m_ovf && !clr) || (wr && !wr_ok);
    m_unf = (m_unf && !clr) || (rd && !rd_ok);
  endtask

  function automatic logic [4:0] status_of(input int cnt, input logic ovf, input logic unf);
    return {cnt == DEPTH, cnt == 0, cnt >= AF, ovf, unf};
  endfunction

  function automatic logic [4:0] dut_status();
    return {full, empty, almost_full, overflow, underflow};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle, advances the model, then checks DUT against the model.
  task automatic step(input logic r, input logic wr, input logic rd,
                      input logic clr, input logic [WIDTH-1:0] din);
    rst     = r;
    wr_en   = wr;
    rd_en   = rd;
    clr_err = clr;
    d       = din;
    @(posedge clk);
    model_step(r, wr, rd, clr, din);
    #1;
    chk("model_q",      q,       m_q);
    chk("model_qvalid", 64'(q_valid), 64'(m_qv));
    chk("model_count",  64'(count),   64'(exp_q.size()));
    chk("model_status", 64'(dut_status()), 64'(status_of(exp_q.size(), m_ovf, m_unf)));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             r, wr, rd, clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             qv;
    int               cnt;
    logic             ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic wr, input logic rd, input logic clr,
                              input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] eq,
                              input logic eqv, input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.r = r; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.q = eq; v.qv = eqv; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  logic [WIDTH-1:0] pv[8];

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; d = '0;
    exp_q.delete();
    m_q = '0; m_qv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

    pv[0] = 64'd1;          pv[1] = -64'd8;
    pv[2] = -64'd3;         pv[3] = 64'd16457;
    pv[4] = 64'd89320567;   pv[5] = 64'd58947128924718;
    pv[6] = -64'd123567;    pv[7] = 64'd55;

    // reset state
    tbl.push_back(mk(1, 0, 0, 0, '0, '0, 0, 0, 0, 0));
    // fill to full
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 0, 0, pv[i], '0, 0, i + 1, 0, 0));
    // push on full with no pop: rejected
    tbl.push_back(mk(0, 1, 0, 0, 64'hAA, '0, 0, 8, 1, 0));
    // clear error flags
    tbl.push_back(mk(0, 0, 0, 1, '0, '0, 0, 8, 0, 0));
    // push + pop on full: both accepted
    tbl.push_back(mk(0, 1, 1, 0, 64'hBB, pv[0], 1, 8, 0, 0));
    // drain: remaining originals in order, then 0xBB
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(0, 0, 1, 0, '0, pv[i], 1, 8 - i, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, '0, 64'hBB, 1, 0, 0, 0));
    // push + pop on empty: only push accepted, q holds
    tbl.push_back(mk(0, 1, 1, 0, 64'h5, 64'hBB, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, '0, 64'h5, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, '0, 64'h5, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      chk($sformatf("vec%0d_q", i),      q,                tbl[i].q);
      chk($sformatf("vec%0d_qvalid", i), 64'(q_valid),     64'(tbl[i].qv));
      chk($sformatf("vec%0d_count", i),  64'(count),       64'(tbl[i].cnt));
      chk($sformatf("vec%0d_status", i), 64'(dut_status()),
          64'(status_of(tbl[i].cnt, tbl[i].ovf, tbl[i].unf)));
    end

    // ---- streaming: push+pop every cycle, pointers wrap several times ----
    step(0, 1, 0, 0, 64'd1);
    chk("stream_prime_count", 64'(count), 64'd1);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 1, 0, 64'(k + 1));
      chk($sformatf("stream%0d_q", k), q, 64'(k));
      chk($sformatf("stream%0d_qvalid", k), 64'(q_valid), 64'd1);
      chk($sformatf("stream%0d_count", k), 64'(count), 64'd1);
      chk($sformatf("stream%0d_flags", k), 64'({overflow, underflow}), 64'd0);
    end
    step(0, 0, 1, 0, '0);
    chk("stream_drain_q", q, 64'd21);
    chk("stream_drain_empty", 64'(empty), 64'd1);

    // ---- reset mid-operation overrides push/pop ----
    step(0, 1, 0, 0, 64'h11);
    step(0, 1, 0, 0, 64'h22);
    step(0, 1, 0, 0, 64'h33);
    chk("prerst_count", 64'(count), 64'd3);
    step(1, 1, 1, 0, 64'h44);
    chk("rst_count",  64'(count),   64'd0);
    chk("rst_empty",  64'(empty),   64'd1);
    chk("rst_q",      q,            64'd0);
    chk("rst_qvalid", 64'(q_valid), 64'd0);
    chk("rst_flags",  64'({overflow, underflow}), 64'd0);
    step(0, 1, 0, 0, 64'h7);
    step(0, 0, 1, 0, '0);
    chk("postrst_q",      q,            64'h7);
    chk("postrst_qvalid", 64'(q_valid), 64'd1);

    // ---- randomized traffic against the model ----
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int c = 0; c < 100; c++) begin
        logic r, wr, rd, clr;
        r   = ($urandom_range(0, 149) == 0);
        wr  = ($urandom_range(0, 99) < wp);
        rd  = ($urandom_range(0, 99) < rp);
        clr = ($urandom_range(0, 9) == 0);
        step(r, wr, rd, clr, {$urandom, $urandom});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
